// File: rtl/bram_readout_if.sv
// Output stream of the capture readout: data beats with valid/ready handshake and last marking.
// The master drives data/valid/last, the slave returns ready.
interface bram_readout_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic              m_last_o;

  modport master (
    output m_data_o,
    output m_valid_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o,
    input  m_valid_o,
    input  m_last_o,
    output m_ready_i
  );
endinterface

// File: rtl/bram_readout.sv
// Streams words 0..N-1 of the capture BRAM out on a valid/ready interface, hiding the BRAM
// read latency behind a small prefetch FIFO. Define READOUT_CHECKSUM_EN to add checksum_o.
module bram_readout #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              pdh_clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   length_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_data_i,
  bram_readout_if.master    m_if
`ifdef READOUT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [ADDR_W:0]  CAP_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE_W     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     issued_q;
  logic [ADDR_W:0]     beats_q;
  logic                bram_en_q;
  logic [ADDR_W-1:0]   bram_addr_q;
  logic                busy_q;
  logic                done_q;

  logic [RD_LAT-1:0]   pipe_q;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;
  logic [CNT_W-1:0]    fifo_cnt_d;

  logic [ADDR_W:0]     len_sat;
  logic [CNT_W-1:0]    inflight_cnt;
  logic [CNT_W-1:0]    occupancy;
  logic                fifo_valid;
  logic                push;
  logic                pop;
  logic                last_beat;
  logic                issue;
  logic                issued_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign len_sat     = (length_i > CAP_WORDS) ? CAP_WORDS : length_i;
  assign fifo_valid  = (fifo_cnt_q != '0);
  assign push        = pipe_q[RD_LAT-1];
  assign pop         = fifo_valid && m_if.m_ready_i;
  assign last_beat   = (beats_q == (len_q - ONE_W));
  assign issued_last = ((issued_q + ONE_W) == len_q);
  assign fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    inflight_cnt = CNT_W'(bram_en_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_q[i]);
    end
  end

  // Every issued read owns a FIFO slot until its beat leaves; the beat popping this
  // cycle frees its slot early so a continuously-ready sink sees one beat per cycle.
  assign occupancy = fifo_cnt_q + inflight_cnt - CNT_W'(pop);
  assign issue     = (state_q == ST_READ) && (issued_q != len_q) && (occupancy < DEPTH_C);

  always_ff @(posedge pdh_clk) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      beats_q     <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bram_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (pop) begin
        beats_q <= beats_q + ONE_W;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q    <= len_sat;
            beats_q  <= '0;
            busy_q   <= 1'b1;
            issued_q <= '0;
            if (len_sat == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              // FIFO is empty here, so the first read needs no space check.
              bram_en_q   <= 1'b1;
              bram_addr_q <= '0;
              issued_q    <= ONE_W;
              state_q     <= (len_sat == ONE_W) ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            bram_en_q   <= 1'b1;
            bram_addr_q <= issued_q[ADDR_W-1:0];
            issued_q    <= issued_q + ONE_W;
            if (issued_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && last_beat) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pdh_clk) begin
    if (rst_i) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      pipe_q[0] <= bram_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge pdh_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bram_data_i;
    end
  end

`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge pdh_clk) begin
    if (rst_i) begin
      checksum_q <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ fifo_mem_q[rd_ptr_q];
    end
  end

  assign checksum_o = checksum_q;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign bram_en_o      = bram_en_q;
  assign bram_addr_o    = bram_addr_q;
  assign m_if.m_valid_o = fifo_valid;
  assign m_if.m_data_o  = fifo_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign m_if.m_last_o  = fifo_valid && last_beat;

endmodule

// File: tb/tb_bram_readout.sv
// Directed bench for bram_readout: BRAM read-port model, stream monitor and one task per scenario.
// Build with READOUT_CHECKSUM_EN defined to also check checksum_o.
module tb_bram_readout;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int CAP    = 1 << ADDR_W;

  logic              pdh_clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   length_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              bram_en_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_data_i;
`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_o;
`endif

  bram_readout_if #(.DATA_W(DATA_W)) m_if ();

  bram_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .pdh_clk     (pdh_clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bram_en_o   (bram_en_o),
    .bram_addr_o (bram_addr_o),
    .bram_data_i (bram_data_i),
    .m_if        (m_if)
`ifdef READOUT_CHECKSUM_EN
    ,
    .checksum_o  (checksum_o)
`endif
  );

  always #5 pdh_clk = ~pdh_clk;

  int unsigned cyc = 0;
  always @(posedge pdh_clk) cyc <= cyc + 1;

  // BRAM read port model with RD_LAT cycles of latency.
  logic [DATA_W-1:0] tb_mem [CAP];
  logic [DATA_W-1:0] bstage [RD_LAT];
  always @(posedge pdh_clk) begin
    bstage[0] <= bram_en_o ? tb_mem[bram_addr_o] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) bstage[i] <= bstage[i-1];
  end
  assign bram_data_i = bstage[RD_LAT-1];

  // Stream / BRAM-port monitor, sampled on the falling edge.
  int                en_cnt = 0, busy_cnt = 0, done_cnt = 0, stab_err = 0;
  int                max_out = 0, out_base = 0, cur_out;
  int unsigned       last_done_cyc = 0;
  logic [DATA_W-1:0] done_chk = '0;
  logic [DATA_W-1:0] beat_data [$];
  int unsigned       beat_cyc [$];
  bit                beat_last [$];
  int                addr_q [$];
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  always @(negedge pdh_clk) begin
    if (rst_i) begin
      out_base   = en_cnt - beat_data.size();
      prev_stall = 1'b0;
    end else begin
      if (bram_en_o) begin
        en_cnt++;
        addr_q.push_back(int'(bram_addr_o));
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
`ifdef READOUT_CHECKSUM_EN
        done_chk = checksum_o;
`endif
      end
      if (prev_stall && (!m_if.m_valid_o || m_if.m_data_o !== prev_data || m_if.m_last_o !== prev_last))
        stab_err++;
      if (m_if.m_valid_o && m_if.m_ready_i) begin
        beat_data.push_back(m_if.m_data_o);
        beat_cyc.push_back(cyc);
        beat_last.push_back(m_if.m_last_o);
      end
      cur_out = en_cnt - beat_data.size() - out_base;
      if (cur_out > max_out) max_out = cur_out;
      prev_stall = m_if.m_valid_o && !m_if.m_ready_i;
      prev_data  = m_if.m_data_o;
      prev_last  = m_if.m_last_o;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic pulse_start(input int len, output int unsigned t0);
    @(posedge pdh_clk); #1;
    start_i  = 1'b1;
    length_i = len[ADDR_W:0];
    t0       = cyc;
    @(posedge pdh_clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pdh_clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge pdh_clk); #1;
      m_if.m_ready_i = bp ? ((cyc % 4) == 0) : 1'b1;
    end
    @(posedge pdh_clk); #1;
  endtask

  task automatic test_reset();
    m_if.m_ready_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge pdh_clk);
    @(negedge pdh_clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else n_pass++;
    n_total++; if (bram_en_o !== 1'b0) $display("FAIL reset_en got %b want 0", bram_en_o); else n_pass++;
    n_total++; if (bram_addr_o !== '0) $display("FAIL reset_addr got %h want 0", bram_addr_o); else n_pass++;
    n_total++; if (m_if.m_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", m_if.m_valid_o); else n_pass++;
    n_total++; if (m_if.m_last_o !== 1'b0) $display("FAIL reset_last got %b want 0", m_if.m_last_o); else n_pass++;
    n_total++; if (m_if.m_data_o !== '0) $display("FAIL reset_data got %h want 0", m_if.m_data_o); else n_pass++;
    @(posedge pdh_clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    int b, e0, bz; int unsigned t0; bit ok;
    for (int k = 0; k < CAP; k++) tb_mem[k] = 32'h100 + k;
    m_if.m_ready_i = 1'b1;
    b = beat_data.size(); e0 = en_cnt; bz = busy_cnt;
    pulse_start(8, t0);
    wait_done(40, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL basic_done_timeout got no done want done"); else n_pass++;
    n_total++; if (beat_data.size() - b != 8) $display("FAIL basic_beats got %0d want 8", beat_data.size() - b); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (b + i >= beat_data.size()) break;
      n_total++; if (beat_data[b+i] !== 32'h100 + i) $display("FAIL basic_data[%0d] got %h want %h", i, beat_data[b+i], 32'h100 + i); else n_pass++;
      n_total++; if (beat_cyc[b+i] - t0 != 4 + i) $display("FAIL basic_cycle[%0d] got %0d want %0d", i, beat_cyc[b+i] - t0, 4 + i); else n_pass++;
      n_total++; if (beat_last[b+i] != (i == 7)) $display("FAIL basic_last[%0d] got %b want %b", i, beat_last[b+i], i == 7); else n_pass++;
    end
    n_total++; if (last_done_cyc - t0 != 12) $display("FAIL basic_done_cycle got %0d want 12", last_done_cyc - t0); else n_pass++;
    n_total++; if (busy_cnt - bz != 12) $display("FAIL basic_busy_cycles got %0d want 12", busy_cnt - bz); else n_pass++;
    n_total++; if (en_cnt - e0 != 8) $display("FAIL basic_reads got %0d want 8", en_cnt - e0); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_zero_length();
    int b, e0, bz; int unsigned t0; bit ok;
    b = beat_data.size(); e0 = en_cnt; bz = busy_cnt;
    pulse_start(0, t0);
    wait_done(10, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL zero_done_timeout got no done want done"); else n_pass++;
    n_total++; if (last_done_cyc - t0 != 1) $display("FAIL zero_done_cycle got %0d want 1", last_done_cyc - t0); else n_pass++;
    n_total++; if (en_cnt - e0 != 0) $display("FAIL zero_reads got %0d want 0", en_cnt - e0); else n_pass++;
    n_total++; if (beat_data.size() - b != 0) $display("FAIL zero_beats got %0d want 0", beat_data.size() - b); else n_pass++;
    n_total++; if (busy_cnt - bz != 1) $display("FAIL zero_busy_cycles got %0d want 1", busy_cnt - bz); else n_pass++;
  endtask

  task automatic test_backpressure();
    int b, e0, bad; int unsigned t0; bit ok;
    for (int k = 0; k < CAP; k++) tb_mem[k] = 32'hA000 + 3 * k;
    m_if.m_ready_i = 1'b0;
    b = beat_data.size(); e0 = en_cnt; bad = 0;
    pulse_start(16, t0);
    wait_done(300, 1'b1, ok);
    m_if.m_ready_i = 1'b1;
    n_total++; if (!ok) $display("FAIL bp_done_timeout got no done want done"); else n_pass++;
    n_total++; if (beat_data.size() - b != 16) $display("FAIL bp_beats got %0d want 16", beat_data.size() - b); else n_pass++;
    for (int i = 0; i < 16 && b + i < beat_data.size(); i++)
      if (beat_data[b+i] !== 32'hA000 + 3 * i || beat_last[b+i] != (i == 15)) bad++;
    n_total++; if (bad != 0) $display("FAIL bp_order got %0d bad beats want 0", bad); else n_pass++;
    n_total++; if (en_cnt - e0 != 16) $display("FAIL bp_reads got %0d want 16", en_cnt - e0); else n_pass++;
    n_total++; if (stab_err != 0) $display("FAIL bp_stable got %0d changes want 0", stab_err); else n_pass++;
    n_total++; if (max_out > RD_LAT + 2) $display("FAIL bp_outstanding got %0d want <= %0d", max_out, RD_LAT + 2); else n_pass++;
  endtask

  task automatic test_saturate();
    int b, e0, a0, zeros, bad; int unsigned t0; bit ok;
    for (int k = 0; k < CAP; k++) tb_mem[k] = k ^ 32'h5A5A_0000;
    m_if.m_ready_i = 1'b1;
    b = beat_data.size(); e0 = en_cnt; a0 = addr_q.size(); zeros = 0; bad = 0;
    pulse_start(CAP + 5, t0);
    wait_done(300, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL sat_done_timeout got no done want done"); else n_pass++;
    n_total++; if (beat_data.size() - b != CAP) $display("FAIL sat_beats got %0d want %0d", beat_data.size() - b, CAP); else n_pass++;
    n_total++; if (en_cnt - e0 != CAP) $display("FAIL sat_reads got %0d want %0d", en_cnt - e0, CAP); else n_pass++;
    for (int i = a0; i < addr_q.size(); i++) if (addr_q[i] == 0) zeros++;
    n_total++; if (zeros != 1) $display("FAIL sat_addr_zero got %0d reads of 0 want 1", zeros); else n_pass++;
    n_total++; if (addr_q[addr_q.size()-1] != CAP - 1) $display("FAIL sat_last_addr got %0d want %0d", addr_q[addr_q.size()-1], CAP - 1); else n_pass++;
    for (int i = 0; i < CAP && b + i < beat_data.size(); i++)
      if (beat_data[b+i] !== (i ^ 32'h5A5A_0000)) bad++;
    n_total++; if (bad != 0) $display("FAIL sat_data got %0d bad beats want 0", bad); else n_pass++;
    n_total++; if (last_done_cyc - t0 != CAP + 4) $display("FAIL sat_done_cycle got %0d want %0d", last_done_cyc - t0, CAP + 4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int b, d0, a0; int unsigned t0; bit ok, hit;
    for (int k = 0; k < CAP; k++) tb_mem[k] = 32'h300 + k;
    m_if.m_ready_i = 1'b1;
    b = beat_data.size(); hit = 1'b0;
    pulse_start(32, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge pdh_clk);
      if (beat_data.size() - b >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++; if (!hit) $display("FAIL mid_reach_beat10 got %0d beats want 10", beat_data.size() - b); else n_pass++;
    @(posedge pdh_clk); #1; rst_i = 1'b1;
    @(posedge pdh_clk); #1; rst_i = 1'b0;
    @(negedge pdh_clk);
    n_total++; if ({busy_o, done_o, bram_en_o, m_if.m_valid_o, m_if.m_last_o} !== 5'b0)
      $display("FAIL mid_ctrl_zero got %b want 00000", {busy_o, done_o, bram_en_o, m_if.m_valid_o, m_if.m_last_o}); else n_pass++;
    n_total++; if (m_if.m_data_o !== '0) $display("FAIL mid_data_zero got %h want 0", m_if.m_data_o); else n_pass++;
    n_total++; if (bram_addr_o !== '0) $display("FAIL mid_addr_zero got %h want 0", bram_addr_o); else n_pass++;
    d0 = done_cnt; b = beat_data.size();
    repeat (8) @(negedge pdh_clk);
    n_total++; if (done_cnt - d0 != 0) $display("FAIL mid_no_done got %0d done pulses want 0", done_cnt - d0); else n_pass++;
    n_total++; if (beat_data.size() - b != 0) $display("FAIL mid_discard got %0d beats want 0", beat_data.size() - b); else n_pass++;
    for (int k = 0; k < 4; k++) tb_mem[k] = 32'h700 + k;
    b = beat_data.size(); a0 = addr_q.size();
    pulse_start(4, t0);
    wait_done(40, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL mid_restart_timeout got no done want done"); else n_pass++;
    n_total++; if (beat_data.size() - b != 4) $display("FAIL mid_restart_beats got %0d want 4", beat_data.size() - b); else n_pass++;
    for (int i = 0; i < 4 && b + i < beat_data.size(); i++) begin
      n_total++; if (beat_data[b+i] !== 32'h700 + i) $display("FAIL mid_restart_data[%0d] got %h want %h", i, beat_data[b+i], 32'h700 + i); else n_pass++;
    end
    for (int i = 0; i < 4 && a0 + i < addr_q.size(); i++) begin
      n_total++; if (addr_q[a0+i] != i) $display("FAIL mid_restart_addr[%0d] got %0d want %0d", i, addr_q[a0+i], i); else n_pass++;
    end
    n_total++; if (last_done_cyc - t0 != 8) $display("FAIL mid_restart_done_cycle got %0d want 8", last_done_cyc - t0); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int b, e0, d0; int unsigned t0; bit ok; logic [DATA_W-1:0] x;
    tb_mem[0] = 32'h1; tb_mem[1] = 32'h2; tb_mem[2] = 32'h4; tb_mem[3] = 32'h8;
    for (int k = 4; k < CAP; k++) tb_mem[k] = 32'hF0 + k;
    m_if.m_ready_i = 1'b1;
    b = beat_data.size(); e0 = en_cnt; d0 = done_cnt;
    pulse_start(4, t0);
    @(posedge pdh_clk); #1; start_i = 1'b1; length_i = 7'd10;
    @(posedge pdh_clk); #1; start_i = 1'b0;
    wait_done(40, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL busy_start_timeout got no done want done"); else n_pass++;
    n_total++; if (last_done_cyc - t0 != 8) $display("FAIL busy_start_done_cycle got %0d want 8", last_done_cyc - t0); else n_pass++;
    x = '0;
    for (int i = b; i < beat_data.size(); i++) x = x ^ beat_data[i];
    n_total++; if (x !== 32'hF) $display("FAIL busy_start_xor got %h want f", x); else n_pass++;
`ifdef READOUT_CHECKSUM_EN
    n_total++; if (done_chk !== 32'hF) $display("FAIL checksum got %h want f", done_chk); else n_pass++;
`endif
    repeat (10) @(negedge pdh_clk);
    n_total++; if (beat_data.size() - b != 4) $display("FAIL busy_start_beats got %0d want 4", beat_data.size() - b); else n_pass++;
    n_total++; if (en_cnt - e0 != 4) $display("FAIL busy_start_reads got %0d want 4", en_cnt - e0); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL busy_start_dones got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL busy_start_idle got %b want 0", busy_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_start_while_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
